// File: rtl/counter_pkg.sv
// Shared types for the parametrised up/down counter.
// Mode encodings and the per-edge operation enum.
package counter_pkg;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    typedef enum logic [2:0] {
        HOLD,
        UP,
        DOWN,
        LOAD,
        CLEAR
    } cnt_op_e;

endpackage

// File: rtl/counter_nextval.sv
// Next count value and wrap/saturate events for one edge.
// All arithmetic runs one bit wider than the count.
module counter_nextval
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_s,
    input  logic [WIDTH-1:0] i_limit,
    input  cnt_op_e          i_op,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_wrap_up,
    output logic             o_wrap_dn,
    output logic             o_sat_evt
);

    logic [WIDTH:0] w_q1;
    logic [WIDTH:0] w_s1;
    logic [WIDTH:0] w_lim1;
    logic [WIDTH:0] w_limp1;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_up_wrap;
    logic [WIDTH:0] w_dn;
    logic [WIDTH:0] w_dn_wrap;

    assign w_q1      = {1'b0, i_q};
    assign w_s1      = {1'b0, i_s};
    assign w_lim1    = {1'b0, i_limit};
    assign w_limp1   = w_lim1 + (WIDTH+1)'(1);
    assign w_sum     = w_q1 + w_s1;
    assign w_up_wrap = w_sum - w_limp1;
    assign w_dn      = w_q1 - w_s1;
    assign w_dn_wrap = w_q1 + w_limp1 - w_s1;

    // Select next value; a count already above limit snaps to a bound on up.
    always_comb begin
        o_next_q  = i_q;
        o_wrap_up = 1'b0;
        o_wrap_dn = 1'b0;
        o_sat_evt = 1'b0;
        case (i_op)
            UP: begin
                if (w_q1 > w_lim1) begin
                    if (i_mode == CNT_SAT) begin
                        o_next_q  = i_limit;
                        o_sat_evt = 1'b1;
                    end else begin
                        o_next_q  = '0;
                        o_wrap_up = 1'b1;
                    end
                end else if (w_sum <= w_lim1) begin
                    o_next_q = w_sum[WIDTH-1:0];
                end else if (i_mode == CNT_SAT) begin
                    o_next_q  = i_limit;
                    o_sat_evt = 1'b1;
                end else begin
                    o_next_q  = w_up_wrap[WIDTH-1:0];
                    o_wrap_up = 1'b1;
                end
            end
            DOWN: begin
                if (w_q1 >= w_s1) begin
                    o_next_q = w_dn[WIDTH-1:0];
                end else if (i_mode == CNT_SAT) begin
                    o_next_q  = '0;
                    o_sat_evt = 1'b1;
                end else begin
                    o_next_q  = w_dn_wrap[WIDTH-1:0];
                    o_wrap_dn = 1'b1;
                end
            end
            default: begin
                o_next_q = i_q;
            end
        endcase
    end

endmodule

// File: rtl/counter_updown_param.sv
// Up/down counter with load, programmable step and modulus,
// wrap/saturate modes, carry/borrow pulses and sticky overflow.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter bit SAT_DEF = 1'b0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              sclr,
    input  logic [WIDTH-1:0]  load,
    input  logic              parallel,
    input  logic              increase,
    input  logic              decrease,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  Q_OUT,
    output logic              carry,
    output logic              borrow,
    output logic              ovf_sticky,
    output logic              at_max,
    output logic              at_min
);

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_mode;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_load_c;
    logic [WIDTH-1:0] w_next_q;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_sat_evt;
    logic             w_unused;
    cnt_op_e          w_op;

    assign w_step   = WIDTH'(step);
    assign w_s      = (w_step > limit) ? limit : w_step;
    assign w_load_c = (load > limit) ? limit : load;

    // Mode changes act on the same edge, so the sampled copy is informational.
    assign w_unused = r_mode;

    // Decode the edge operation: clear, then load, then a nonzero count.
    always_comb begin
        w_op = HOLD;
        if (sclr) begin
            w_op = CLEAR;
        end else if (parallel) begin
            w_op = LOAD;
        end else if ((increase ^ decrease) && (w_s != '0)) begin
            w_op = increase ? UP : DOWN;
        end
    end

    counter_nextval #(
        .WIDTH (WIDTH)
    ) u_nextval (
        .i_q       (r_q),
        .i_s       (w_s),
        .i_limit   (limit),
        .i_op      (w_op),
        .i_mode    (sat_mode),
        .o_next_q  (w_next_q),
        .o_wrap_up (w_wrap_up),
        .o_wrap_dn (w_wrap_dn),
        .o_sat_evt (w_sat_evt)
    );

    // Count, pulse and sticky-flag registers; a set event beats clr_flags.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q      <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_mode   <= SAT_DEF;
        end else begin
            r_mode <= sat_mode;
            case (w_op)
                CLEAR: begin
                    r_q      <= '0;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                    r_ovf    <= 1'b0;
                end
                LOAD: begin
                    r_q      <= w_load_c;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                    r_ovf    <= r_ovf & ~clr_flags;
                end
                default: begin
                    r_q      <= w_next_q;
                    r_carry  <= w_wrap_up;
                    r_borrow <= w_wrap_dn;
                    r_ovf    <= w_wrap_up | w_wrap_dn | w_sat_evt
                              | (r_ovf & ~clr_flags);
                end
            endcase
        end
    end

    assign Q_OUT      = r_q;
    assign carry      = r_carry;
    assign borrow     = r_borrow;
    assign ovf_sticky = r_ovf;
    assign at_max     = (r_q == limit);
    assign at_min     = (r_q == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed self-checking bench for counter_updown_param.
// Expected values are hand-computed for WIDTH=8, limit=9.
module tb_counter_updown_param;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       sclr;
    logic [7:0] load;
    logic       parallel;
    logic       increase;
    logic       decrease;
    logic [3:0] step;
    logic [7:0] limit;
    logic       sat_mode;
    logic       clr_flags;
    logic [7:0] Q_OUT;
    logic       carry;
    logic       borrow;
    logic       ovf_sticky;
    logic       at_max;
    logic       at_min;

    int checks = 0;
    int errors = 0;

    counter_updown_param #(
        .WIDTH   (8),
        .STEP_W  (4),
        .SAT_DEF (1'b0)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .sclr       (sclr),
        .load       (load),
        .parallel   (parallel),
        .increase   (increase),
        .decrease   (decrease),
        .step       (step),
        .limit      (limit),
        .sat_mode   (sat_mode),
        .clr_flags  (clr_flags),
        .Q_OUT      (Q_OUT),
        .carry      (carry),
        .borrow     (borrow),
        .ovf_sticky (ovf_sticky),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_sclr;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = v;
        parallel = 1'b1;
        tick();
        parallel = 1'b0;
    endtask

    task automatic test_reset;
        CLR = 1'b0; sclr = 1'b0; load = '0; parallel = 1'b0;
        increase = 1'b0; decrease = 1'b0; step = 4'd1;
        limit = 8'd9; sat_mode = 1'b0; clr_flags = 1'b0;
        #1;
        checks++;
        if (Q_OUT !== 8'd0) begin
            errors++; $display("FAIL reset_q: got %0d want 0", Q_OUT);
        end
        checks++;
        if ({carry, borrow, ovf_sticky} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {carry, borrow, ovf_sticky});
        end
        checks++;
        if ({at_max, at_min} !== 2'b01) begin
            errors++; $display("FAIL reset_at: got %b want 01", {at_max, at_min});
        end
        @(posedge CLK); @(posedge CLK); #3;
        CLR = 1'b1;
        tick();
    endtask

    task automatic test_up_wrap;
        logic [7:0] eq;
        logic       ec;
        logic       eo;
        increase = 1'b1; step = 4'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            eq = 8'((i + 1) % 10);
            ec = (i == 9);
            eo = (i >= 9);
            checks++;
            if (Q_OUT !== eq) begin
                errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, Q_OUT, eq);
            end
            checks++;
            if ({carry, borrow, ovf_sticky} !== {ec, 1'b0, eo}) begin
                errors++;
                $display("FAIL up_flags[%0d]: got %b want %b", i,
                         {carry, borrow, ovf_sticky}, {ec, 1'b0, eo});
            end
        end
        increase = 1'b0;
    endtask

    task automatic test_down_wrap;
        logic [7:0] eq [4] = '{8'd7, 8'd4, 8'd1, 8'd8};
        logic       eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_sclr();
        checks++;
        if ({Q_OUT, ovf_sticky} !== {8'd0, 1'b0}) begin
            errors++; $display("FAIL sclr: got q=%0d ovf=%b want 0/0", Q_OUT, ovf_sticky);
        end
        decrease = 1'b1; step = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({Q_OUT, borrow, carry} !== {eq[i], eb[i], 1'b0}) begin
                errors++;
                $display("FAIL down[%0d]: got q=%0d b=%b c=%b want q=%0d b=%b c=0",
                         i, Q_OUT, borrow, carry, eq[i], eb[i]);
            end
        end
        decrease = 1'b0;
    endtask

    task automatic test_saturate;
        do_load(8'd8);
        sat_mode = 1'b1; increase = 1'b1; step = 4'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({Q_OUT, carry, ovf_sticky, at_max} !== {8'd9, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL sat[%0d]: got q=%0d c=%b o=%b m=%b want 9/0/1/1",
                         i, Q_OUT, carry, ovf_sticky, at_max);
            end
        end
        increase = 1'b0; sat_mode = 1'b0;
    endtask

    task automatic test_step_clamp;
        do_sclr();
        increase = 1'b1; step = 4'd15;
        tick();
        checks++;
        if ({Q_OUT, carry, ovf_sticky} !== {8'd9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clamp1: got q=%0d c=%b o=%b want 9/0/0", Q_OUT, carry, ovf_sticky);
        end
        tick();
        checks++;
        if ({Q_OUT, carry, ovf_sticky} !== {8'd8, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL clamp2: got q=%0d c=%b o=%b want 8/1/1", Q_OUT, carry, ovf_sticky);
        end
        step = 4'd0;
        tick();
        checks++;
        if ({Q_OUT, carry, borrow} !== {8'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL step0: got q=%0d c=%b b=%b want 8/0/0", Q_OUT, carry, borrow);
        end
        increase = 1'b0; step = 4'd1;
    endtask

    task automatic test_load;
        do_sclr();
        do_load(8'd200);
        checks++;
        if ({Q_OUT, carry, borrow, ovf_sticky} !== {8'd9, 3'b000}) begin
            errors++;
            $display("FAIL load_clamp: got q=%0d c=%b b=%b o=%b want 9/0/0/0",
                     Q_OUT, carry, borrow, ovf_sticky);
        end
        increase = 1'b1; decrease = 1'b1; step = 4'd2;
        do_load(8'd4);
        checks++;
        if (Q_OUT !== 8'd4) begin
            errors++; $display("FAIL load_prio: got %0d want 4", Q_OUT);
        end
        tick();
        checks++;
        if ({Q_OUT, carry, borrow} !== {8'd4, 2'b00}) begin
            errors++;
            $display("FAIL both_hold: got q=%0d c=%b b=%b want 4/0/0", Q_OUT, carry, borrow);
        end
        increase = 1'b0; decrease = 1'b0; step = 4'd1;
    endtask

    task automatic test_limit_drop;
        do_load(8'd5);
        limit = 8'd3; increase = 1'b1;
        tick();
        checks++;
        if ({Q_OUT, carry} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL drop_wrap: got q=%0d c=%b want 0/1", Q_OUT, carry);
        end
        increase = 1'b0; limit = 8'd9;
        do_sclr();
        do_load(8'd5);
        limit = 8'd3; sat_mode = 1'b1; increase = 1'b1;
        tick();
        checks++;
        if ({Q_OUT, carry, ovf_sticky, at_max} !== {8'd3, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL drop_sat: got q=%0d c=%b o=%b m=%b want 3/0/1/1",
                     Q_OUT, carry, ovf_sticky, at_max);
        end
        increase = 1'b0; sat_mode = 1'b0; limit = 8'd9;
    endtask

    task automatic test_async_and_flags;
        do_load(8'd9);
        increase = 1'b1; step = 4'd2;
        tick();
        checks++;
        if ({Q_OUT, carry} !== {8'd1, 1'b1}) begin
            errors++; $display("FAIL pre_rst: got q=%0d c=%b want 1/1", Q_OUT, carry);
        end
        #2;
        CLR = 1'b0;
        #1;
        checks++;
        if ({Q_OUT, carry, ovf_sticky} !== {8'd0, 2'b00}) begin
            errors++;
            $display("FAIL async_rst: got q=%0d c=%b o=%b want 0/0/0", Q_OUT, carry, ovf_sticky);
        end
        step = 4'd1;
        #2;
        CLR = 1'b1;
        tick();
        checks++;
        if ({Q_OUT, carry} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL post_rst: got q=%0d c=%b want 1/0", Q_OUT, carry);
        end
        increase = 1'b0;
        sclr = 1'b1; parallel = 1'b1; load = 8'd7;
        tick();
        sclr = 1'b0; parallel = 1'b0;
        checks++;
        if (Q_OUT !== 8'd0) begin
            errors++; $display("FAIL sclr_prio: got %0d want 0", Q_OUT);
        end
        do_load(8'd9);
        increase = 1'b1; clr_flags = 1'b1;
        tick();
        checks++;
        if ({Q_OUT, carry, ovf_sticky} !== {8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL set_wins: got q=%0d c=%b o=%b want 0/1/1", Q_OUT, carry, ovf_sticky);
        end
        increase = 1'b0;
        tick();
        checks++;
        if ({carry, ovf_sticky} !== 2'b00) begin
            errors++;
            $display("FAIL clr_flags: got c=%b o=%b want 0/0", carry, ovf_sticky);
        end
        clr_flags = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_step_clamp();
        test_load();
        test_limit_drop();
        test_async_and_flags();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
